// File: rtl/batch_scheduler_if.sv
// Sample-in / replay-out bundle of the batch scheduler.
// Handshake: in_valid is a single-cycle strobe with no ready. The scheduler
// accepts every strobed sample; a batch that cannot be processed is reported
// through the sticky overflow flag instead of backpressure. rec_en and
// out_valid are likewise pure strobes qualifying sel and out_idx.
interface batch_scheduler_if #(
  parameter int N     = 3,
  parameter int DEPTH = 32
);
  localparam int IW = $clog2(DEPTH);

  logic [N-1:0]  in;
  logic          in_valid;
  logic [N-1:0]  sel;
  logic          rec_en;
  logic          rec_clear;
  logic          pass;
  logic          busy;
  logic          out_valid;
  logic [IW-1:0] out_idx;
  logic          overflow;

  // Sample source / result consumer side
  modport master (
    output in, in_valid,
    input  sel, rec_en, rec_clear, pass, busy, out_valid, out_idx, overflow
  );

  // Scheduler side
  modport slave (
    input  in, in_valid,
    output sel, rec_en, rec_clear, pass, busy, out_valid, out_idx, overflow
  );
endinterface

// File: rtl/batch_scheduler.sv
// Batch scheduler: ping-pong sample banks replayed backwards into the
// LUT/recursion datapath, with latency-aligned out_valid/out_idx.
// Optional forward pass after the backward pass: define BATCH_FWD_PASS_EN.
module batch_scheduler #(
  parameter int N     = 3,
  parameter int DEPTH = 32,
  parameter int LAT   = 2
) (
  input  logic               clk,
  input  logic               rst,
  batch_scheduler_if.slave   bus,
  output logic [1:0]         o_dbg_state
);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BWD  = 2'd1,
    S_FWD  = 2'd2
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_wr_ptr;
  logic [IW-1:0] r_rd_ptr;
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [N-1:0]  r_mem [2*DEPTH];

  logic [N-1:0]  r_sel;
  logic [IW-1:0] r_idx;
  logic          r_rec_en;
  logic          r_rec_clear;
  logic          r_pass;
  logic          r_overflow;

  logic          w_full;
  logic          w_last_read;
  logic          w_free;
  logic          w_handoff;

  // The write that lands in the last slot of the write bank completes a batch
  assign w_full = bus.in_valid && (r_wr_ptr == IW'(DEPTH - 1));

  // The final read of the last pass frees the processor at that same edge
`ifdef BATCH_FWD_PASS_EN
  assign w_last_read = (r_state == S_FWD) && (r_rd_ptr == IW'(DEPTH - 1));
`else
  assign w_last_read = (r_state == S_BWD) && (r_rd_ptr == '0);
`endif
  assign w_free    = (r_state == S_IDLE) || w_last_read;
  assign w_handoff = w_full && w_free;

  // Sample storage; bank contents need no reset
  always_ff @(posedge clk) begin
    if (bus.in_valid) r_mem[{r_wr_bank, r_wr_ptr}] <= bus.in;
  end

  // Write pointer/bank control, overflow flag and the replay FSM
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_sel       <= '0;
      r_idx       <= '0;
      r_rec_en    <= 1'b0;
      r_rec_clear <= 1'b0;
      r_pass      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_rec_en    <= 1'b0;
      r_rec_clear <= 1'b0;
      r_pass      <= 1'b0;

      if (bus.in_valid) begin
        // DEPTH is a power of two, so the pointer wraps naturally
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_full) begin
          if (w_free) begin
            r_wr_bank <= ~r_wr_bank;
            r_rd_bank <= r_wr_bank;
          end else begin
            // Keep writing the same bank; the batch in flight is untouched
            r_overflow <= 1'b1;
          end
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_handoff) begin
            r_state  <= S_BWD;
            r_rd_ptr <= IW'(DEPTH - 1);
          end
        end
        S_BWD: begin
          r_sel       <= r_mem[{r_rd_bank, r_rd_ptr}];
          r_idx       <= r_rd_ptr;
          r_rec_en    <= 1'b1;
          r_rec_clear <= (r_rd_ptr == IW'(DEPTH - 1));
          r_rd_ptr    <= r_rd_ptr - 1'b1;
          if (r_rd_ptr == '0) begin
            if (w_handoff) begin
              r_state  <= S_BWD;
              r_rd_ptr <= IW'(DEPTH - 1);
            end else begin
`ifdef BATCH_FWD_PASS_EN
              r_state  <= S_FWD;
              r_rd_ptr <= '0;
`else
              r_state  <= S_IDLE;
`endif
            end
          end
        end
`ifdef BATCH_FWD_PASS_EN
        S_FWD: begin
          r_sel       <= r_mem[{r_rd_bank, r_rd_ptr}];
          r_idx       <= r_rd_ptr;
          r_rec_en    <= 1'b1;
          r_rec_clear <= (r_rd_ptr == '0);
          r_pass      <= 1'b1;
          r_rd_ptr    <= r_rd_ptr + 1'b1;
          if (r_rd_ptr == IW'(DEPTH - 1)) begin
            if (w_handoff) begin
              r_state  <= S_BWD;
              r_rd_ptr <= IW'(DEPTH - 1);
            end else begin
              r_state  <= S_IDLE;
            end
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Align valid/index with the datapath latency
  generate
    if (LAT == 0) begin : g_nolat
      assign bus.out_valid = r_rec_en;
      assign bus.out_idx   = r_idx;
    end else begin : g_lat
      logic [LAT-1:0] r_dly_v;
      logic [IW-1:0]  r_dly_i [LAT];

      // Shift register cleared on reset so no stale strobes survive an abort
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_dly_v <= '0;
          for (int i = 0; i < LAT; i++) r_dly_i[i] <= '0;
        end else begin
          r_dly_v[0] <= r_rec_en;
          r_dly_i[0] <= r_idx;
          for (int i = 1; i < LAT; i++) begin
            r_dly_v[i] <= r_dly_v[i-1];
            r_dly_i[i] <= r_dly_i[i-1];
          end
        end
      end

      assign bus.out_valid = r_dly_v[LAT-1];
      assign bus.out_idx   = r_dly_i[LAT-1];
    end
  endgenerate

  assign bus.sel       = r_sel;
  assign bus.rec_en    = r_rec_en;
  assign bus.rec_clear = r_rec_clear;
  assign bus.pass      = r_pass;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.overflow  = r_overflow;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_batch_scheduler.sv
// Directed bench for batch_scheduler (N=3, DEPTH=4, LAT=2).
module tb_batch_scheduler;
  localparam int N     = 3;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;

  typedef struct {
    logic       vld;
    logic [2:0] din;
    logic       rec;
    logic       clr;
    logic [2:0] sel;
    logic       busy;
    logic       ovv;
    logic [1:0] oidx;
    logic       pass;
    logic       ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] dbg_state;
  vec_t       tbl[$];
  int         n_pass  = 0;
  int         n_total = 0;

  batch_scheduler_if #(.N(N), .DEPTH(DEPTH)) bus ();

  batch_scheduler #(.N(N), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input logic vld, input logic [2:0] din);
    bus.in_valid = vld;
    bus.in       = din;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(1'b0, 3'd0);
    step(1'b0, 3'd0);
    rst = 1'b1;
  endtask

  task automatic add(input int vld, input int din, input int rec, input int clr,
                     input int sel, input int busy, input int ovv, input int oidx,
                     input int pass, input int ovf);
    vec_t v;
    v.vld  = 1'(vld);
    v.din  = 3'(din);
    v.rec  = 1'(rec);
    v.clr  = 1'(clr);
    v.sel  = 3'(sel);
    v.busy = 1'(busy);
    v.ovv  = 1'(ovv);
    v.oidx = 2'(oidx);
    v.pass = 1'(pass);
    v.ovf  = 1'(ovf);
    tbl.push_back(v);
  endtask

  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      step(tbl[i].vld, tbl[i].din);
      check($sformatf("%s[%0d] rec_en", tag, i), 32'(bus.rec_en), 32'(tbl[i].rec));
      check($sformatf("%s[%0d] rec_clear", tag, i), 32'(bus.rec_clear), 32'(tbl[i].clr));
      check($sformatf("%s[%0d] busy", tag, i), 32'(bus.busy), 32'(tbl[i].busy));
      check($sformatf("%s[%0d] pass", tag, i), 32'(bus.pass), 32'(tbl[i].pass));
      check($sformatf("%s[%0d] out_valid", tag, i), 32'(bus.out_valid), 32'(tbl[i].ovv));
      check($sformatf("%s[%0d] overflow", tag, i), 32'(bus.overflow), 32'(tbl[i].ovf));
      if (tbl[i].rec)
        check($sformatf("%s[%0d] sel", tag, i), 32'(bus.sel), 32'(tbl[i].sel));
      if (tbl[i].ovv)
        check($sformatf("%s[%0d] out_idx", tag, i), 32'(bus.out_idx), 32'(tbl[i].oidx));
    end
    tbl.delete();
  endtask

  initial begin
    int cnt0;
    int cnt1;
    int nclr;

    bus.in_valid = 1'b0;
    bus.in       = '0;

    // Reset held 3 cycles with samples strobing: everything stays cleared
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 3'd5);
    check("rst rec_en", 32'(bus.rec_en), 32'd0);
    check("rst rec_clear", 32'(bus.rec_clear), 32'd0);
    check("rst sel", 32'(bus.sel), 32'd0);
    check("rst pass", 32'(bus.pass), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst out_idx", 32'(bus.out_idx), 32'd0);
    check("rst overflow", 32'(bus.overflow), 32'd0);
    check("rst state", 32'(dbg_state), 32'd0);
    rst = 1'b1;

`ifndef BATCH_FWD_PASS_EN
    // One batch 1,2,3,4 replayed as 4,3,2,1; index 0 holds the first sample
    //  vld din rec clr sel busy ovv oidx pass ovf
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 4, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 1, 4, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 3, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 2, 1, 1, 3, 0, 0);
    add(0, 0, 1, 0, 1, 0, 1, 2, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_table("single");

    // Twelve back-to-back samples: three seamless bursts, never overflowing
    do_reset();
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 4, 0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 5, 1, 1, 4, 1, 0, 0, 0, 0);
    add(1, 6, 1, 0, 3, 1, 0, 0, 0, 0);
    add(1, 7, 1, 0, 2, 1, 1, 3, 0, 0);
    add(1, 0, 1, 0, 1, 1, 1, 2, 0, 0);
    add(1, 1, 1, 1, 0, 1, 1, 1, 0, 0);
    add(1, 2, 1, 0, 7, 1, 1, 0, 0, 0);
    add(1, 3, 1, 0, 6, 1, 1, 3, 0, 0);
    add(1, 4, 1, 0, 5, 1, 1, 2, 0, 0);
    add(0, 0, 1, 1, 4, 1, 1, 1, 0, 0);
    add(0, 0, 1, 0, 3, 1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 2, 1, 1, 3, 0, 0);
    add(0, 0, 1, 0, 1, 0, 1, 2, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_table("cont");
`else
    // Continuous input with the forward pass: second batch overflows
    //  vld din rec clr sel busy ovv oidx pass ovf
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 4, 0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 5, 1, 1, 4, 1, 0, 0, 0, 0);
    add(1, 6, 1, 0, 3, 1, 0, 0, 0, 0);
    add(1, 7, 1, 0, 2, 1, 1, 3, 0, 0);
    add(1, 0, 1, 0, 1, 1, 1, 2, 0, 1);
    add(1, 1, 1, 1, 1, 1, 1, 1, 1, 1);
    add(1, 2, 1, 0, 2, 1, 1, 0, 1, 1);
    add(1, 3, 1, 0, 3, 1, 1, 0, 1, 1);
    add(1, 4, 1, 0, 4, 1, 1, 1, 1, 1);
    add(0, 0, 1, 1, 4, 1, 1, 2, 0, 1);
    add(0, 0, 1, 0, 3, 1, 1, 3, 0, 1);
    add(0, 0, 1, 0, 2, 1, 1, 3, 0, 1);
    add(0, 0, 1, 0, 1, 1, 1, 2, 0, 1);
    add(0, 0, 1, 1, 1, 1, 1, 1, 1, 1);
    add(0, 0, 1, 0, 2, 1, 1, 0, 1, 1);
    add(0, 0, 1, 0, 3, 1, 1, 0, 1, 1);
    add(0, 0, 1, 0, 4, 0, 1, 1, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1, 2, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 3, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    run_table("fwdcont");
`endif

    // Half-rate input: two banks, no overflow, count strobes per pass
    do_reset();
    cnt0 = 0;
    cnt1 = 0;
    nclr = 0;
    for (int i = 0; i < 40; i++) begin
      if (i < 16) step(((i % 2) == 0), 3'(i / 2 + 1));
      else        step(1'b0, 3'd0);
      if (bus.rec_en && !bus.pass) cnt0++;
      if (bus.rec_en && bus.pass)  cnt1++;
      if (bus.rec_clear)           nclr++;
    end
    check("half overflow", 32'(bus.overflow), 32'd0);
    check("half busy", 32'(bus.busy), 32'd0);
    check("half bwd count", 32'(cnt0), 32'd8);
`ifdef BATCH_FWD_PASS_EN
    check("half fwd count", 32'(cnt1), 32'd8);
    check("half clear count", 32'(nclr), 32'd4);
`else
    check("half fwd count", 32'(cnt1), 32'd0);
    check("half clear count", 32'(nclr), 32'd2);
`endif

    // Reset during the second backward read aborts with no stale strobes
    do_reset();
    for (int i = 1; i <= 4; i++) step(1'b1, 3'(i));
    step(1'b0, 3'd0);
    check("abort first rec_en", 32'(bus.rec_en), 32'd1);
    check("abort first sel", 32'(bus.sel), 32'd4);
    rst = 1'b0;
    step(1'b0, 3'd0);
    check("abort rec_en", 32'(bus.rec_en), 32'd0);
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort out_valid", 32'(bus.out_valid), 32'd0);
    check("abort state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'd0);
      check($sformatf("abort tail%0d out_valid", i), 32'(bus.out_valid), 32'd0);
      check($sformatf("abort tail%0d rec_en", i), 32'(bus.rec_en), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
